multicycle_control: RTL

- Parametrised successor to the processor's main multicycle control FSM. Sequences fetch, decode, execute, memory and writeback for the full 16-instruction ISA, including the shift and slti ops.
- Adds a memory-ready wait handshake, a bounded-wait timeout with a bus-error flag, an illegal-opcode trap and an instruction-complete strobe.
- Sits between the IR op/func fields and the datapath write enables and muxes.

---
 rtl/ctrl_pkg.sv | 57 +++++
 rtl/wait_timer.sv | 43 ++++
 rtl/multicycle_control.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: opcodes, func codes, states, mux selects.
// Pure declarations; no timing or flow control of its own.
package ctrl_pkg;

   localparam logic [3:0] OP_RTYPE = 4'h0;
   localparam logic [3:0] OP_ADDI  = 4'h1;
   localparam logic [3:0] OP_BEQ   = 4'h2;
   localparam logic [3:0] OP_BNE   = 4'h3;
   localparam logic [3:0] OP_J     = 4'h4;
   localparam logic [3:0] OP_LW    = 4'h5;
   localparam logic [3:0] OP_SW    = 4'h6;
   localparam logic [3:0] OP_LI    = 4'h8;
   localparam logic [3:0] OP_ORI   = 4'h9;
   localparam logic [3:0] OP_ANDI  = 4'hA;
   localparam logic [3:0] OP_NORI  = 4'hB;
   localparam logic [3:0] OP_SLL   = 4'hC;
   localparam logic [3:0] OP_SRL   = 4'hD;
   localparam logic [3:0] OP_SRA   = 4'hE;
   localparam logic [3:0] OP_SLTI  = 4'hF;

   localparam logic [3:0] FN_COPY  = 4'h6;
   localparam logic [3:0] FN_JR    = 4'h7;

   typedef enum logic [4:0] {
      S_IDLE     = 5'd0,
      S_FETCH    = 5'd1,
      S_DECODE   = 5'd2,
      S_EXEC_R   = 5'd3,
      S_EXEC_I   = 5'd4,
      S_WB_ALU   = 5'd5,
      S_BRANCH   = 5'd6,
      S_JUMP     = 5'd7,
      S_JR       = 5'd8,
      S_JR_GO    = 5'd9,
      S_COPY_WB  = 5'd10,
      S_LI_WB    = 5'd11,
      S_MEM_ADDR = 5'd12,
      S_MEM_RD   = 5'd13,
      S_MEM_WB   = 5'd14,
      S_MEM_WR   = 5'd15,
      S_ILLEGAL  = 5'd16
   } state_e;

   localparam logic [1:0] WD_MEM  = 2'b00;
   localparam logic [1:0] WD_ALU  = 2'b01;
   localparam logic [1:0] WD_A    = 2'b10;
   localparam logic [1:0] WD_IMM  = 2'b11;

   localparam logic [1:0] IR_R2   = 2'b00;
   localparam logic [1:0] IR_SEXT = 2'b01;
   localparam logic [1:0] IR_PC1  = 2'b10;

   localparam logic [1:0] JMP_NONE = 2'b00;
   localparam logic [1:0] JMP_J    = 2'b01;
   localparam logic [1:0] JMP_JR   = 2'b10;

endpackage

// File: rtl/wait_timer.sv
// Counts consecutive memory-wait cycles and flags a timeout at MAX_WAIT (never when MAX_WAIT = 0).
// Timeout is combinational from the count and en; clr has priority over counting.
module wait_timer #(
   parameter int MAX_WAIT = 15
) (
   input  logic CLK,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic timeout
);
   import ctrl_pkg::*;

   localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   generate
      if (MAX_WAIT == 0) begin : g_no_tmo
         assign timeout = 1'b0;
      end else begin : g_tmo
         assign timeout = en && (cnt_q == CNT_W'(MAX_WAIT));
      end
   endgenerate

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback with memory-ready waits, timeout and illegal trap.
// Latency 3-5 cycles per instruction plus memory waits; stalls in FETCH/MEM_RD/MEM_WR until mem_ready.
module multicycle_control #(
   parameter int OP_W        = 4,
   parameter int FUNC_W      = 4,
   parameter bit MEM_WAIT_EN = 1'b1,
   parameter int MAX_WAIT    = 15
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic [OP_W-1:0]   op,
   input  logic [FUNC_W-1:0] func,
   input  logic              mem_ready,
   output logic              pc_wrt,
   output logic              ir_wrt,
   output logic              mem_o_wrt,
   output logic              a_wrt,
   output logic              b_wrt,
   output logic              alu_wrt,
   output logic              reg_wrt,
   output logic              mem_wrt,
   output logic              branch,
   output logic              bne_not_beq,
   output logic [1:0]        jump,
   output logic [1:0]        w_dat,
   output logic [1:0]        im_or_r,
   output logic              w_adrs,
   output logic              mem_adrs_slct,
   output logic              imm_slct,
   output logic              instr_done,
   output logic              illegal,
   output logic              bus_err,
   output logic [4:0]        state
);
   import ctrl_pkg::*;

   state_e state_q, state_d;
   logic   rdy, in_wait, tmo;

   assign rdy     = MEM_WAIT_EN ? mem_ready : 1'b1;
   assign in_wait = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
   assign state   = state_q;

   wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
      .CLK     (CLK),
      .reset   (reset),
      .clr     (state_d != state_q),
      .en      (in_wait && !rdy),
      .timeout (tmo)
   );

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_wrt        = 1'b0;
      ir_wrt        = 1'b0;
      mem_o_wrt     = 1'b0;
      a_wrt         = 1'b0;
      b_wrt         = 1'b0;
      alu_wrt       = 1'b0;
      reg_wrt       = 1'b0;
      mem_wrt       = 1'b0;
      branch        = 1'b0;
      bne_not_beq   = 1'b0;
      jump          = JMP_NONE;
      w_dat         = WD_MEM;
      im_or_r       = IR_R2;
      w_adrs        = 1'b0;
      mem_adrs_slct = 1'b0;
      imm_slct      = 1'b0;
      instr_done    = 1'b0;
      illegal       = 1'b0;
      bus_err       = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            pc_wrt = rdy;
            ir_wrt = rdy;
            if (rdy) state_d = S_DECODE;
         end
         S_DECODE: begin
            a_wrt = 1'b1;
            b_wrt = 1'b1;
            // Zero-extended compares: any op with high bits set falls through to the trap.
            case (op)
               OP_W'(OP_RTYPE): begin
                  if (func == FUNC_W'(FN_JR))        state_d = S_JR;
                  else if (func == FUNC_W'(FN_COPY)) state_d = S_COPY_WB;
                  else                               state_d = S_EXEC_R;
               end
               OP_W'(OP_ADDI), OP_W'(OP_ORI), OP_W'(OP_ANDI), OP_W'(OP_NORI),
               OP_W'(OP_SLL), OP_W'(OP_SRL), OP_W'(OP_SRA), OP_W'(OP_SLTI):
                  state_d = S_EXEC_I;
               OP_W'(OP_BEQ), OP_W'(OP_BNE): state_d = S_BRANCH;
               OP_W'(OP_J):                  state_d = S_JUMP;
               OP_W'(OP_LW), OP_W'(OP_SW):   state_d = S_MEM_ADDR;
               OP_W'(OP_LI):                 state_d = S_LI_WB;
               default:                      state_d = S_ILLEGAL;
            endcase
         end
         S_EXEC_R: begin
            alu_wrt = 1'b1;
            im_or_r = IR_R2;
            state_d = S_WB_ALU;
         end
         S_EXEC_I: begin
            alu_wrt = 1'b1;
            im_or_r = IR_SEXT;
            state_d = S_WB_ALU;
         end
         S_WB_ALU: begin
            reg_wrt    = 1'b1;
            w_dat      = WD_ALU;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            branch      = 1'b1;
            bne_not_beq = op[0];
            instr_done  = 1'b1;
            state_d     = S_FETCH;
         end
         S_JUMP: begin
            jump       = JMP_J;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_JR: begin
            im_or_r = IR_PC1;
            alu_wrt = 1'b1;
            state_d = S_JR_GO;
         end
         S_JR_GO: begin
            jump       = JMP_JR;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_COPY_WB: begin
            reg_wrt    = 1'b1;
            w_dat      = WD_A;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_LI_WB: begin
            reg_wrt    = 1'b1;
            w_dat      = WD_IMM;
            imm_slct   = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_ADDR: begin
            alu_wrt = 1'b1;
            im_or_r = IR_SEXT;
            state_d = (op == OP_W'(OP_SW)) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            mem_adrs_slct = 1'b1;
            mem_o_wrt     = rdy;
            if (rdy) begin
               state_d = S_MEM_WB;
            end else if (tmo) begin
               bus_err = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_MEM_WB: begin
            reg_wrt    = 1'b1;
            w_dat      = WD_MEM;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_WR: begin
            mem_adrs_slct = 1'b1;
            mem_wrt       = 1'b1;
            if (rdy) begin
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end else if (tmo) begin
               bus_err = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_ILLEGAL: begin
            illegal    = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule
